// File: rtl/msg_scroller.sv
// Scrolling-message sequencer: walks a fixed code stream through a NUM_DIGITS window
// and time-multiplexes the visible codes onto the digit enables of a 7-segment decoder.
module msg_scroller #(
  parameter int unsigned MSG_LEN    = 15,
  parameter int unsigned BLANK_GAP  = 2,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STEP_DIV   = 10000000,
  parameter int unsigned MUX_DIV    = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  restart,
  output logic [3:0]            char_code,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  wrap_pulse
);

  localparam int unsigned L  = MSG_LEN + BLANK_GAP;
  localparam int unsigned HW = 5;
  localparam int unsigned PW = 6;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  logic [HW-1:0]         head, head_nxt;
  logic [DW-1:0]         dig, dig_nxt;
  logic [SW-1:0]         step_cnt, step_nxt;
  logic [MW-1:0]         mux_cnt, mux_nxt;
  logic                  tick;
  logic                  wrap_nxt;
  logic [PW-1:0]         pos_sum, pos;
  logic [3:0]            code_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  // Next-state and next-output computation; outputs use post-edge values so they never lag
  always_comb begin
    mux_nxt  = mux_cnt + MW'(1);
    dig_nxt  = dig;
    step_nxt = step_cnt;
    head_nxt = head;
    wrap_nxt = 1'b0;
    tick     = run && (step_cnt == SW'(STEP_DIV - 1));

    if (mux_cnt == MW'(MUX_DIV - 1)) begin
      mux_nxt = '0;
      dig_nxt = (dig == DW'(NUM_DIGITS - 1)) ? '0 : dig + DW'(1);
    end

    // restart wins over a coincident tick, which is then dropped without a wrap
    if (restart) begin
      step_nxt = '0;
      head_nxt = '0;
    end else if (run) begin
      step_nxt = tick ? '0 : step_cnt + SW'(1);
      if (tick) begin
        if (!dir) head_nxt = (head == HW'(L - 1)) ? '0 : head + HW'(1);
        else      head_nxt = (head == '0) ? HW'(L - 1) : head - HW'(1);
        wrap_nxt = (head_nxt == '0);
      end
    end

    pos_sum  = PW'(head_nxt) + PW'(dig_nxt);
    pos      = (pos_sum >= PW'(L)) ? pos_sum - PW'(L) : pos_sum;
    code_nxt = (pos < PW'(MSG_LEN)) ? 4'(pos + PW'(1)) : 4'd0;
    sel_nxt  = NUM_DIGITS'(1) << dig_nxt;
  end

  // State and registered outputs; ena=0 freezes state and blanks the display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      dig        <= '0;
      step_cnt   <= '0;
      mux_cnt    <= '0;
      char_code  <= '0;
      digit_sel  <= '0;
      wrap_pulse <= 1'b0;
    end else if (ena) begin
      head       <= head_nxt;
      dig        <= dig_nxt;
      step_cnt   <= step_nxt;
      mux_cnt    <= mux_nxt;
      char_code  <= code_nxt;
      digit_sel  <= sel_nxt;
      wrap_pulse <= wrap_nxt;
    end else begin
      char_code  <= '0;
      digit_sel  <= '0;
      wrap_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msg_scroller.sv
// Directed bench for msg_scroller with STEP_DIV=4, MUX_DIV=1, NUM_DIGITS=4, L=17.
module tb_msg_scroller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       run;
  logic       dir;
  logic       restart;
  logic [3:0] char_code;
  logic [3:0] digit_sel;
  logic       wrap_pulse;

  int checks = 0;
  int errors = 0;
  int exp_dig = 0;
  int wraps = 0;

  msg_scroller #(
    .MSG_LEN   (15),
    .BLANK_GAP (2),
    .NUM_DIGITS(4),
    .STEP_DIV  (4),
    .MUX_DIV   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .run       (run),
    .dir       (dir),
    .restart   (restart),
    .char_code (char_code),
    .digit_sel (digit_sel),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; sample 1 time unit after it and track the expected digit index
  task automatic cyc();
    @(posedge clk);
    #1;
    if (ena && rst_n) exp_dig = (exp_dig + 1) % 4;
    if (wrap_pulse) wraps++;
  endtask

  task automatic run_steps(input int n);
    run = 1'b1;
    repeat (n) cyc();
    run = 1'b0;
  endtask

  // win holds the four visible codes, leftmost digit in the top nibble
  task automatic check_window(input string tag, input logic [15:0] win);
    logic [3:0] e;
    for (int k = 0; k < 4; k++) begin
      cyc();
      e = 4'(win >> (4 * (3 - exp_dig)));
      chk({tag, "_sel"}, int'(digit_sel), 1 << exp_dig);
      chk({tag, "_code"}, int'(char_code), int'(e));
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; run = 1'b0; dir = 1'b0; restart = 1'b0;
    #12;
    chk("rst_code", int'(char_code), 0);
    chk("rst_sel", int'(digit_sel), 0);
    chk("rst_wrap", int'(wrap_pulse), 0);
    rst_n = 1'b1;
    exp_dig = 0;

    check_window("init", {4'd1, 4'd2, 4'd3, 4'd4});

    wraps = 0;
    run_steps(16);
    chk("fwd4_wrap", wraps, 0);
    check_window("fwd4", {4'd5, 4'd6, 4'd7, 4'd8});

    run_steps(44);
    chk("fwd15_wrap", wraps, 0);
    check_window("fwd15", {4'd0, 4'd0, 4'd1, 4'd2});

    run_steps(8);
    chk("fwdwrap_cnt", wraps, 1);
    check_window("fwdwrap", {4'd1, 4'd2, 4'd3, 4'd4});

    dir = 1'b1;
    wraps = 0;
    run_steps(4);
    chk("bk16_wrap", wraps, 0);
    check_window("bk16", {4'd0, 4'd1, 4'd2, 4'd3});

    run_steps(60);
    chk("bk1_wrap", wraps, 0);
    check_window("bk1", {4'd2, 4'd3, 4'd4, 4'd5});

    run_steps(4);
    chk("bkwrap_cnt", wraps, 1);
    check_window("bkwrap", {4'd1, 4'd2, 4'd3, 4'd4});

    // Reach head=16 with step_cnt=3, then restart on the tick cycle
    wraps = 0;
    run_steps(4);
    run_steps(3);
    dir = 1'b0;
    restart = 1'b1;
    run_steps(1);
    restart = 1'b0;
    chk("rs_wrap", wraps, 0);
    check_window("rs_head0", {4'd1, 4'd2, 4'd3, 4'd4});
    run_steps(3);
    check_window("rs_3cyc", {4'd1, 4'd2, 4'd3, 4'd4});
    run_steps(1);
    check_window("rs_4cyc", {4'd2, 4'd3, 4'd4, 4'd5});

    // Freeze with step_cnt=2; restart during ena=0 must be ignored
    run_steps(2);
    ena = 1'b0;
    restart = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("off_code", int'(char_code), 0);
      chk("off_sel", int'(digit_sel), 0);
    end
    restart = 1'b0;
    ena = 1'b1;
    run_steps(2);
    check_window("resume", {4'd3, 4'd4, 4'd5, 4'd6});

    wraps = 0;
    run_steps(28);
    chk("h9_wrap", wraps, 0);
    check_window("h9", {4'd10, 4'd11, 4'd12, 4'd13});

    rst_n = 1'b0;
    #1;
    chk("arst_code", int'(char_code), 0);
    chk("arst_sel", int'(digit_sel), 0);
    chk("arst_wrap", int'(wrap_pulse), 0);
    #2;
    rst_n = 1'b1;
    exp_dig = 0;
    check_window("post_rst", {4'd1, 4'd2, 4'd3, 4'd4});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
